// File: rtl/temp_poll_ctrl.sv
// temp_poll_ctrl: command-side sequencer for the SPI master. It writes one sensor config
// register after reset, then polls the temperature register and publishes samples and an alarm.
//
// state  | meaning
// SYNC   | wait for trans_done high 4 consecutive clocks (master idle)
// CFG_GO | load the config write and toggle start_trans
// WAIT   | poll interval down-counter running
// RD_GO  | load the temperature read and toggle start_trans
// ACK    | wait for the master to drop trans_done
// BUSY   | wait for the master to raise trans_done
// CAP    | capture the sample, pulse temp_valid, update alarm
module temp_poll_ctrl #(
  parameter int unsigned       POLL_DIV = 50000,
  parameter logic [7:0]        CFG_CMD  = 8'h08,
  parameter logic [7:0]        CFG_VAL  = 8'h80,
  parameter logic [7:0]        RD_CMD   = 8'h50,
  parameter int unsigned       ACK_TO   = 8,
  parameter int unsigned       DONE_TO  = 1024,
  parameter logic signed [15:0] ALARM_HI = 16'sd1280,
  parameter logic signed [15:0] ALARM_LO = 16'sd1200
) (
  input  logic        sck_in,
  input  logic        rst_n,
  output logic        start_trans,
  input  logic        trans_done,
  output logic [3:0]  in_bytes_count,
  output logic [3:0]  out_bytes_count,
  output logic [31:0] in_bytes,
  input  logic [31:0] out_bytes,
  output logic [15:0] temp_q,
  output logic        temp_valid,
  output logic        alarm,
  output logic        err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    S_SYNC, S_CFG_GO, S_WAIT, S_RD_GO, S_ACK, S_BUSY, S_CAP
  } state_t;

  localparam logic [23:0] POLL_LD = 24'(POLL_DIV - 1);
  localparam logic [23:0] ACK_LD  = 24'(ACK_TO - 1);
  localparam logic [23:0] DONE_LD = 24'(DONE_TO - 1);

  state_t      state;
  logic [23:0] timer;
  logic [1:0]  sync_cnt;
  logic        cfg_done;
  logic        ret_cap;

  logic signed [15:0] temp_new;
  logic               unused_hi;

  // Sensor delivers a left-justified 13-bit reading; the low 3 bits are flags.
  assign temp_new  = $signed(out_bytes[15:0]) >>> 3;
  assign unused_hi = ^out_bytes[31:16];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge sck_in or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_SYNC;
      timer           <= '0;
      sync_cnt        <= '0;
      cfg_done        <= 1'b0;
      ret_cap         <= 1'b0;
      start_trans     <= 1'b0;
      in_bytes_count  <= '0;
      out_bytes_count <= '0;
      in_bytes        <= '0;
      temp_q          <= '0;
      temp_valid      <= 1'b0;
      alarm           <= 1'b0;
      err             <= 1'b0;
      err_cnt         <= '0;
    end else begin
      temp_valid <= 1'b0;
      case (state)
        S_SYNC: begin
          if (!trans_done) begin
            sync_cnt <= '0;
          end else if (sync_cnt == 2'd3) begin
            sync_cnt <= '0;
            if (cfg_done) begin
              timer <= POLL_LD;
              state <= S_WAIT;
            end else begin
              state <= S_CFG_GO;
            end
          end else begin
            sync_cnt <= sync_cnt + 2'd1;
          end
        end
        S_CFG_GO: begin
          if (!trans_done) begin
            err_cnt <= sat_inc(err_cnt);
            state   <= S_SYNC;
          end else begin
            in_bytes_count  <= 4'd2;
            out_bytes_count <= 4'd0;
            in_bytes        <= {16'h0, CFG_CMD, CFG_VAL};
            start_trans     <= ~start_trans;
            ret_cap         <= 1'b0;
            timer           <= ACK_LD;
            state           <= S_ACK;
          end
        end
        S_WAIT: begin
          if (!trans_done) begin
            err_cnt <= sat_inc(err_cnt);
            state   <= S_SYNC;
          end else if (timer == '0) begin
            state <= S_RD_GO;
          end else begin
            timer <= timer - 24'd1;
          end
        end
        S_RD_GO: begin
          if (!trans_done) begin
            err_cnt <= sat_inc(err_cnt);
            state   <= S_SYNC;
          end else begin
            in_bytes_count  <= 4'd1;
            out_bytes_count <= 4'd2;
            in_bytes        <= {24'h0, RD_CMD};
            start_trans     <= ~start_trans;
            ret_cap         <= 1'b1;
            timer           <= ACK_LD;
            state           <= S_ACK;
          end
        end
        S_ACK: begin
          if (!trans_done) begin
            timer <= DONE_LD;
            state <= S_BUSY;
          end else if (timer == '0) begin
            err     <= 1'b1;
            err_cnt <= sat_inc(err_cnt);
            state   <= S_SYNC;
          end else begin
            timer <= timer - 24'd1;
          end
        end
        S_BUSY: begin
          if (trans_done) begin
            if (ret_cap) begin
              state <= S_CAP;
            end else begin
              cfg_done <= 1'b1;
              timer    <= POLL_LD;
              state    <= S_WAIT;
            end
          end else if (timer == '0) begin
            err     <= 1'b1;
            err_cnt <= sat_inc(err_cnt);
            state   <= S_SYNC;
          end else begin
            timer <= timer - 24'd1;
          end
        end
        S_CAP: begin
          temp_q     <= temp_new;
          temp_valid <= 1'b1;
          if (temp_new >= ALARM_HI)
            alarm <= 1'b1;
          else if (temp_new < ALARM_LO)
            alarm <= 1'b0;
          timer <= POLL_LD;
          state <= S_WAIT;
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule
